rw_mem_ctrl: RTL and testbench

- Command-driven initiator for the 16x8 single-port synchronous RAM (write on posedge when WE=1, otherwise registered read).
- Drives the RAM's Address, Data_In and WE and consumes its Data_Out.
- Executes block FILL, COPY and SUM (8-bit checksum) operations over a wrapping address range.
- Sits between a host sequencer and the RAM; the host only sees a Start/Busy/Done handshake.

---
 rtl/rw_mem_ctrl.sv | 156 +++++++++++++++
 tb/tb_rw_mem_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rw_mem_ctrl.sv
// Command-driven FILL / COPY / SUM sequencer for a single-port synchronous RAM with registered read.
// Every output is registered; the RAM samples Mem_* at the edge that ends each cycle.
module rw_mem_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [1:0]        Op,
    input  logic [ADDR_W-1:0] Src,
    input  logic [ADDR_W-1:0] Dst,
    input  logic [ADDR_W:0]   Len,
    input  logic [DATA_W-1:0] Pattern,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic [DATA_W-1:0] Result,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [DATA_W-1:0] Mem_Data_In,
    output logic              Mem_WE,
    input  logic [DATA_W-1:0] Mem_Data_Out
);

    typedef enum logic [2:0] {
        IDLE, FILL_WR, CP_RD, CP_CAP, CP_WR, SUM_RD, SUM_CAP, DONE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

    state_t              state_q;
    logic [ADDR_W-1:0]   src_q;
    logic [ADDR_W-1:0]   dst_q;
    logic [ADDR_W:0]     cnt_q;
    logic [DATA_W-1:0]   acc_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic [DATA_W-1:0]   result_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   din_q;
    logic                we_q;
    logic [ADDR_W:0]     len_c;

    assign len_c = (Len > DEPTH) ? DEPTH : Len;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            result_q <= '0;
            addr_q   <= '0;
            din_q    <= '0;
            we_q     <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            we_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        busy_q <= 1'b1;
                        src_q  <= Src;
                        dst_q  <= Dst;
                        cnt_q  <= len_c;
                        acc_q  <= '0;
                        if (Op == 2'b11 || len_c == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            error_q <= (Op == 2'b11);
                            if (Op == 2'b10) result_q <= '0;
                        end else if (Op == 2'b00) begin
                            state_q <= FILL_WR;
                            addr_q  <= Dst;
                            din_q   <= Pattern;
                            we_q    <= 1'b1;
                        end else if (Op == 2'b01) begin
                            state_q <= CP_RD;
                            addr_q  <= Src;
                        end else begin
                            state_q <= SUM_RD;
                            addr_q  <= Src;
                        end
                    end
                end
                FILL_WR: begin
                    if (cnt_q == ONE) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                        cnt_q  <= cnt_q - ONE;
                        we_q   <= 1'b1;
                    end
                end
                CP_RD:  state_q <= CP_CAP;
                CP_CAP: begin
                    // Read data is valid this cycle; hold it for the write that follows.
                    din_q   <= Mem_Data_Out;
                    addr_q  <= dst_q;
                    we_q    <= 1'b1;
                    state_q <= CP_WR;
                end
                CP_WR: begin
                    if (cnt_q == ONE) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        src_q   <= src_q + 1'b1;
                        dst_q   <= dst_q + 1'b1;
                        addr_q  <= src_q + 1'b1;
                        cnt_q   <= cnt_q - ONE;
                        state_q <= CP_RD;
                    end
                end
                SUM_RD: state_q <= SUM_CAP;
                SUM_CAP: begin
                    acc_q <= acc_q + Mem_Data_Out;
                    if (cnt_q == ONE) begin
                        result_q <= acc_q + Mem_Data_Out;
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                    end else begin
                        addr_q  <= addr_q + 1'b1;
                        cnt_q   <= cnt_q - ONE;
                        state_q <= SUM_RD;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Error       = error_q;
    assign Result      = result_q;
    assign Mem_Address = addr_q;
    assign Mem_Data_In = din_q;
    assign Mem_WE      = we_q;

endmodule

// File: tb/tb_rw_mem_ctrl.sv
// Directed bench for rw_mem_ctrl with a behavioural 16x8 RAM and a completion scoreboard.
module tb_rw_mem_ctrl;

    logic       Clock;
    logic       Reset_n;
    logic       Start;
    logic [1:0] Op;
    logic [3:0] Src;
    logic [3:0] Dst;
    logic [4:0] Len;
    logic [7:0] Pattern;
    logic       Busy;
    logic       Done;
    logic       Error;
    logic [7:0] Result;
    logic [3:0] Mem_Address;
    logic [7:0] Mem_Data_In;
    logic       Mem_WE;
    logic [7:0] Mem_Data_Out;

    rw_mem_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Op(Op),
        .Src(Src), .Dst(Dst), .Len(Len), .Pattern(Pattern),
        .Busy(Busy), .Done(Done), .Error(Error), .Result(Result),
        .Mem_Address(Mem_Address), .Mem_Data_In(Mem_Data_In),
        .Mem_WE(Mem_WE), .Mem_Data_Out(Mem_Data_Out)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // RAM model plus a backdoor write port used only while the controller is idle.
    logic [7:0] mem [16];
    logic [7:0] ram_q;
    logic       bd_we;
    logic [3:0] bd_adr;
    logic [7:0] bd_dat;

    always @(posedge Clock) begin
        if (bd_we)       mem[bd_adr] <= bd_dat;
        else if (Mem_WE) mem[Mem_Address] <= Mem_Data_In;
        else             ram_q <= mem[Mem_Address];
    end
    assign Mem_Data_Out = ram_q;

    typedef struct {
        int         cyc;
        logic [7:0] res;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         wr_cyc[$];
    logic [3:0] wr_adr[$];

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic bd_write(input logic [3:0] a, input logic [7:0] d);
        bd_we  = 1'b1;
        bd_adr = a;
        bd_dat = d;
        @(negedge Clock);
        bd_we  = 1'b0;
    endtask

    // Issue one command at a negedge; cycle 1 is the cycle after the accepting edge.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [3:0] src,
                           input logic [3:0] dst, input logic [4:0] len, input logic [7:0] pat,
                           input int exp_cyc, input logic [7:0] exp_res, input logic exp_err,
                           input int exp_wr, input int poke_lo, input int poke_hi);
        exp_t e;
        int   got;
        got = 0;
        wr_cyc.delete();
        wr_adr.delete();
        Op = op; Src = src; Dst = dst; Len = len; Pattern = pat; Start = 1'b1;
        e.cyc = exp_cyc; e.res = exp_res; e.err = exp_err;
        sb.push_back(e);
        @(negedge Clock);
        Start = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            if (Mem_WE) begin
                wr_cyc.push_back(k);
                wr_adr.push_back(Mem_Address);
            end
            Start = (k >= poke_lo && k <= poke_hi);
            if (Start) begin
                Op = ~op; Src = ~src; Dst = ~dst; Len = 5'd7; Pattern = ~pat;
            end
            if (Done) begin
                got = k;
                break;
            end
            @(negedge Clock);
        end
        e = sb.pop_front();
        chk({tag, "_done_cycle"}, got, e.cyc);
        chk({tag, "_result"}, Result, e.res);
        chk({tag, "_error"}, Error, e.err);
        chk({tag, "_writes"}, wr_cyc.size(), exp_wr);
        @(negedge Clock);
        Start = 1'b0;
        chk({tag, "_idle_after"}, {Busy, Done, Error, Mem_WE}, 4'b0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    int         fa[4];
    int         nwe;
    int         ndone;
    logic       busy_late;

    initial begin
        Reset_n = 1'b0; Start = 1'b1; Op = 2'b00; Src = 4'd0; Dst = 4'd0;
        Len = 5'd4; Pattern = 8'hFF; bd_we = 1'b0; bd_adr = 4'd0; bd_dat = 8'd0;

        // Reset held two cycles with a FILL request pending.
        for (int c = 0; c < 2; c++) begin
            @(negedge Clock);
            chk("reset_outputs", {Busy, Done, Error, Result, Mem_Address, Mem_Data_In, Mem_WE},
                32'd0);
        end
        Start = 1'b0;
        Reset_n = 1'b1;
        @(negedge Clock);
        chk("reset_release_idle", {Busy, Mem_WE}, 2'b00);

        for (int i = 0; i < 16; i++) bd_write(4'(i), 8'h00);
        bd_write(4'd2, 8'h77);

        // FILL across the wrap point.
        run_cmd("fill_wrap", 2'b00, 4'd0, 4'd14, 5'd4, 8'hAA, 5, 8'h00, 1'b0, 4, 0, 0);
        fa = '{14, 15, 0, 1};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fill_adr%0d", i), (i < wr_adr.size()) ? 32'(wr_adr[i]) : 32'hFFFF_FFFF, fa[i]);
            chk($sformatf("fill_cyc%0d", i), (i < wr_cyc.size()) ? wr_cyc[i] : -1, i + 1);
            chk($sformatf("fill_mem%0d", fa[i]), mem[fa[i]], 8'hAA);
        end
        chk("fill_mem2_untouched", mem[2], 8'h77);

        // SUM over the full RAM, then a short all-ones block.
        for (int i = 0; i < 16; i++) bd_write(4'(i), 8'(i + 1));
        run_cmd("sum16", 2'b10, 4'd0, 4'd0, 5'd16, 8'h00, 33, 8'h88, 1'b0, 0, 0, 0);
        for (int i = 0; i < 3; i++) bd_write(4'(i), 8'hFF);
        run_cmd("sum3", 2'b10, 4'd0, 4'd0, 5'd3, 8'h00, 7, 8'hFD, 1'b0, 0, 0, 0);

        // Overlapping COPY propagates the first word forward.
        bd_write(4'd2, 8'h11); bd_write(4'd3, 8'h22);
        bd_write(4'd4, 8'h33); bd_write(4'd5, 8'h44);
        run_cmd("copy_ovl", 2'b01, 4'd2, 4'd3, 5'd3, 8'h00, 10, 8'hFD, 1'b0, 3, 0, 0);
        for (int i = 2; i <= 5; i++) chk($sformatf("copy_mem%0d", i), mem[i], 8'h11);

        // Corner commands.
        run_cmd("len0", 2'b00, 4'd0, 4'd0, 5'd0, 8'h99, 1, 8'hFD, 1'b0, 0, 0, 0);
        chk("len0_mem0", mem[0], 8'hFF);
        run_cmd("op11", 2'b11, 4'd0, 4'd0, 5'd4, 8'h99, 1, 8'hFD, 1'b1, 0, 0, 0);
        run_cmd("start_busy", 2'b00, 4'd0, 4'd6, 5'd3, 8'h3C, 4, 8'hFD, 1'b0, 3, 2, 4);
        chk("start_busy_mem8", mem[8], 8'h3C);
        chk("start_busy_mem9", mem[9], 8'h0A);
        for (int i = 0; i < 16; i++) bd_write(4'(i), 8'(i + 1));
        run_cmd("len20", 2'b10, 4'd5, 4'd0, 5'd20, 8'h00, 33, 8'h88, 1'b0, 0, 0, 0);

        // Reset in the middle of a COPY.
        for (int i = 0; i < 4; i++) bd_write(4'(i), 8'(8'hA1 + i));
        for (int i = 8; i < 12; i++) bd_write(4'(i), 8'h5A);
        Op = 2'b01; Src = 4'd0; Dst = 4'd8; Len = 5'd4; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        nwe = 0; ndone = 0; busy_late = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (Mem_WE) nwe++;
            if (Done) ndone++;
            if (k >= 5) busy_late = busy_late | Busy;
            if (k == 5) begin
                chk("rst_mid_outputs", {Busy, Mem_WE, Done}, 3'b000);
                chk("rst_mid_result", Result, 8'h00);
            end
            if (k == 4) Reset_n = 1'b0;
            if (k == 5) Reset_n = 1'b1;
            @(negedge Clock);
        end
        chk("rst_mid_writes", nwe, 1);
        chk("rst_mid_no_done", ndone, 0);
        chk("rst_mid_busy_low", busy_late, 1'b0);
        chk("rst_mid_mem8", mem[8], 8'hA1);
        for (int i = 9; i < 12; i++) chk($sformatf("rst_mid_mem%0d", i), mem[i], 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
